hdmi_video_encoder: RTL and testbench



---
 rtl/hdmi_video_encoder.sv | 176 +++++++++++++++++
 tb/tb_hdmi_video_encoder.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/hdmi_video_encoder.sv
// HDMI/DVI video transmitter: CEA-861 raster timing, pixel coordinates and
// TMDS encoding of 24-bit RGB into three 10-bit channel words.
module hdmi_video_encoder #(
    parameter int VIDEO_ID_CODE = 4,
    parameter bit DVI_OUTPUT    = 1'b0,
    parameter int START_X       = 0,
    parameter int START_Y       = 0
) (
    input  logic            clk_pixel,
    input  logic            reset,
    input  logic [23:0]     rgb,
    output logic [10:0]     cx,
    output logic [9:0]      cy,
    output logic [10:0]     frame_width,
    output logic [9:0]      frame_height,
    output logic [2:0][9:0] tmds,
    output logic [9:0]      tmds_clock
);

    generate
        if (VIDEO_ID_CODE != 1 && VIDEO_ID_CODE != 4) begin : g_bad_id
            $error("hdmi_video_encoder: unsupported VIDEO_ID_CODE");
        end
    endgenerate

    localparam bit          ID1      = (VIDEO_ID_CODE == 1);
    localparam logic [10:0] H_ACT    = ID1 ? 11'd640 : 11'd1280;
    localparam logic [10:0] H_FP     = ID1 ? 11'd16  : 11'd110;
    localparam logic [10:0] H_SYNC   = ID1 ? 11'd96  : 11'd40;
    localparam logic [10:0] H_BP     = ID1 ? 11'd48  : 11'd220;
    localparam logic [9:0]  V_ACT    = ID1 ? 10'd480 : 10'd720;
    localparam logic [9:0]  V_FP     = ID1 ? 10'd10  : 10'd5;
    localparam logic [9:0]  V_SYNC   = ID1 ? 10'd2   : 10'd5;
    localparam logic [9:0]  V_BP     = ID1 ? 10'd33  : 10'd20;
    localparam bit          SYNC_POS = !ID1;
    localparam logic [10:0] H_TOT    = H_ACT + H_FP + H_SYNC + H_BP;
    localparam logic [9:0]  V_TOT    = V_ACT + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] GUARD_02 = 10'b1011001100;
    localparam logic [9:0] GUARD_1  = 10'b0100110011;

    typedef enum logic [1:0] {
        PER_CTRL,
        PER_PREAMBLE,
        PER_GUARD,
        PER_VIDEO
    } period_e;

    typedef struct packed {
        logic [9:0]        sym;
        logic signed [5:0] cnt;
    } enc_t;

    function automatic logic [9:0] ctrl_sym(input logic [1:0] c);
        case (c)
            2'b00:   return 10'b1101010100;
            2'b01:   return 10'b0010101011;
            2'b10:   return 10'b0101010100;
            default: return 10'b1010101011;
        endcase
    endfunction

    // cnt tracks ones-minus-zeros of the transmitted stream for this channel.
    function automatic enc_t tmds_encode(input logic [7:0] d, input logic signed [5:0] cnt);
        logic [8:0]        qm;
        logic [3:0]        n1;
        logic signed [5:0] diff;
        enc_t              r;
        n1    = 4'($countones(d));
        qm    = '0;
        qm[0] = d[0];
        if (n1 > 4'd4 || (n1 == 4'd4 && !d[0])) begin
            for (int unsigned i = 1; i < 8; i++) qm[i] = ~(qm[i-1] ^ d[i]);
            qm[8] = 1'b0;
        end else begin
            for (int unsigned i = 1; i < 8; i++) qm[i] = qm[i-1] ^ d[i];
            qm[8] = 1'b1;
        end
        diff = $signed({1'b0, 4'($countones(qm[7:0])), 1'b0}) - 6'sd8;
        r    = '0;
        if (cnt == 6'sd0 || diff == 6'sd0) begin
            r.sym = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
            r.cnt = qm[8] ? cnt + diff : cnt - diff;
        end else if ((cnt > 6'sd0 && diff > 6'sd0) || (cnt < 6'sd0 && diff < 6'sd0)) begin
            r.sym = {1'b1, qm[8], ~qm[7:0]};
            r.cnt = cnt - diff + (qm[8] ? 6'sd2 : 6'sd0);
        end else begin
            r.sym = {1'b0, qm[8], qm[7:0]};
            r.cnt = cnt + diff - (qm[8] ? 6'sd0 : 6'sd2);
        end
        return r;
    endfunction

    logic [10:0]       cx_q, cx_d;
    logic [9:0]        cy_q, cy_d;
    logic [2:0][9:0]   tmds_q, tmds_d;
    logic signed [5:0] cnt_q [3];
    logic signed [5:0] cnt_d [3];

    logic    active, hs_in, vs_in, hsync, vsync, next_line_active;
    period_e period;
    enc_t    enc;

    always_comb begin
        cx_d = cx_q + 11'd1;
        cy_d = cy_q;
        if (cx_q == H_TOT - 11'd1) begin
            cx_d = '0;
            cy_d = (cy_q == V_TOT - 10'd1) ? '0 : cy_q + 10'd1;
        end
    end

    always_comb begin
        active           = (cx_q < H_ACT) && (cy_q < V_ACT);
        hs_in            = (cx_q >= H_ACT + H_FP) && (cx_q < H_ACT + H_FP + H_SYNC);
        vs_in            = (cy_q >= V_ACT + V_FP) && (cy_q < V_ACT + V_FP + V_SYNC);
        hsync            = SYNC_POS ? hs_in : ~hs_in;
        vsync            = SYNC_POS ? vs_in : ~vs_in;
        next_line_active = (cy_q == V_TOT - 10'd1) || (cy_q < V_ACT - 10'd1);
        period           = PER_CTRL;
        if (active) begin
            period = PER_VIDEO;
        end else if (!DVI_OUTPUT && next_line_active && cx_q >= H_TOT - 11'd2) begin
            period = PER_GUARD;
        end else if (!DVI_OUTPUT && next_line_active && cx_q >= H_TOT - 11'd10) begin
            period = PER_PREAMBLE;
        end
    end

    // Disparity is only carried across consecutive video cycles; every blank cycle clears it.
    always_comb begin
        enc       = '0;
        cnt_d     = '{default: '0};
        tmds_d[0] = ctrl_sym({vsync, hsync});
        tmds_d[1] = ctrl_sym(2'b00);
        tmds_d[2] = ctrl_sym(2'b00);
        case (period)
            PER_VIDEO: begin
                for (int unsigned ch = 0; ch < 3; ch++) begin
                    enc        = tmds_encode(rgb[8*ch +: 8], cnt_q[ch]);
                    tmds_d[ch] = enc.sym;
                    cnt_d[ch]  = enc.cnt;
                end
            end
            PER_GUARD: begin
                tmds_d[0] = GUARD_02;
                tmds_d[1] = GUARD_1;
                tmds_d[2] = GUARD_02;
            end
            PER_PREAMBLE: tmds_d[1] = ctrl_sym(2'b01);
            default: ;
        endcase
    end

    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            cx_q   <= 11'(START_X);
            cy_q   <= 10'(START_Y);
            tmds_q <= {3{10'b1101010100}};
            cnt_q  <= '{default: '0};
        end else begin
            cx_q   <= cx_d;
            cy_q   <= cy_d;
            tmds_q <= tmds_d;
            cnt_q  <= cnt_d;
        end
    end

    assign cx           = cx_q;
    assign cy           = cy_q;
    assign tmds         = tmds_q;
    assign frame_width  = H_TOT;
    assign frame_height = V_TOT;
    assign tmds_clock   = 10'b0000011111;

endmodule

// File: tb/tb_hdmi_video_encoder.sv
// Bench for hdmi_video_encoder (720p): coordinates, sync, preamble/guard band,
// TMDS decode of active pixels and disparity, and an asynchronous mid-line reset.
module tb_hdmi_video_encoder;

    localparam logic [9:0] C00 = 10'b1101010100;
    localparam logic [9:0] C01 = 10'b0010101011;
    localparam logic [9:0] C10 = 10'b0101010100;
    localparam logic [9:0] C11 = 10'b1010101011;
    localparam logic [9:0] G0  = 10'b1011001100;
    localparam logic [9:0] G1  = 10'b0100110011;
    localparam logic [9:0] TCK = 10'b0000011111;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset;
    logic [23:0]     rgb;
    logic [10:0]     cx [3];
    logic [9:0]      cy [3];
    logic [10:0]     fw [3];
    logic [9:0]      fh [3];
    logic [2:0][9:0] tm [3];
    logic [9:0]      tclk [3];

    // u0: HDMI from row 0; u1: HDMI from row 717; u2: DVI from row 717.
    hdmi_video_encoder #(.VIDEO_ID_CODE(4), .DVI_OUTPUT(1'b0), .START_X(0), .START_Y(0)) dut (
        .clk_pixel(clk), .reset(reset), .rgb(rgb), .cx(cx[0]), .cy(cy[0]),
        .frame_width(fw[0]), .frame_height(fh[0]), .tmds(tm[0]), .tmds_clock(tclk[0]));
    hdmi_video_encoder #(.VIDEO_ID_CODE(4), .DVI_OUTPUT(1'b0), .START_X(0), .START_Y(717)) dut_tail (
        .clk_pixel(clk), .reset(reset), .rgb(rgb), .cx(cx[1]), .cy(cy[1]),
        .frame_width(fw[1]), .frame_height(fh[1]), .tmds(tm[1]), .tmds_clock(tclk[1]));
    hdmi_video_encoder #(.VIDEO_ID_CODE(4), .DVI_OUTPUT(1'b1), .START_X(0), .START_Y(717)) dut_dvi (
        .clk_pixel(clk), .reset(reset), .rgb(rgb), .cx(cx[2]), .cy(cy[2]),
        .frame_width(fw[2]), .frame_height(fh[2]), .tmds(tm[2]), .tmds_clock(tclk[2]));

    int n_checks = 0;
    int n_errors = 0;

    int          mx;
    int          my [3];
    int          px;
    int          py [3];
    logic [23:0] prgb;
    int          disp [3][3];
    int          hs_cnt;
    int          vs_lines;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] dec(input logic [9:0] w);
        logic [7:0] q, d;
        q    = w[9] ? ~w[7:0] : w[7:0];
        d[0] = q[0];
        for (int i = 1; i < 8; i++) d[i] = w[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
        return d;
    endfunction

    function automatic logic [9:0] ctrl(input logic [1:0] c);
        case (c)
            2'b00:   return C00;
            2'b01:   return C01;
            2'b10:   return C10;
            default: return C11;
        endcase
    endfunction

    function automatic logic [9:0] exp_blank(input int u, input int ch, input int x, input int y);
        logic hs, vs, pre_line;
        hs       = (x >= 1390) && (x < 1430);
        vs       = (y >= 725) && (y < 730);
        pre_line = (u != 2) && (y == 749 || y < 719);
        if (pre_line && x >= 1648) return (ch == 1) ? G1 : G0;
        if (ch == 0) return ctrl({vs, hs});
        if (ch == 1 && pre_line && x >= 1640) return C01;
        return C00;
    endfunction

    // Drive rgb for the coordinate now presented, remember it, advance the model.
    task automatic prime();
        rgb  = (my[0] == 0) ? 24'h000000 : 24'($urandom);
        px   = mx;
        prgb = rgb;
        for (int u = 0; u < 3; u++) py[u] = my[u];
        mx = mx + 1;
        if (mx == 1650) begin
            mx = 0;
            for (int u = 0; u < 3; u++) my[u] = (my[u] == 749) ? 0 : my[u] + 1;
        end
    endtask

    task automatic reset_model();
        mx    = 0;
        my[0] = 0;
        my[1] = 717;
        my[2] = 717;
        hs_cnt = 0;
        for (int u = 0; u < 3; u++)
            for (int c = 0; c < 3; c++) disp[u][c] = 0;
    endtask

    task automatic step();
        logic [9:0] w;
        @(negedge clk);
        for (int u = 0; u < 3; u++) begin
            check($sformatf("u%0d_cx", u), 32'(cx[u]), 32'(mx));
            check($sformatf("u%0d_cy", u), 32'(cy[u]), 32'(my[u]));
            check($sformatf("u%0d_tmds_clock", u), 32'(tclk[u]), 32'(TCK));
            for (int c = 0; c < 3; c++) begin
                w = tm[u][c];
                if (px < 1280 && py[u] < 720) begin
                    check($sformatf("u%0d_ch%0d_decode(%0d,%0d)", u, c, px, py[u]),
                          32'(dec(w)), 32'(prgb[8*c +: 8]));
                    disp[u][c] = disp[u][c] + 2 * $countones(w) - 10;
                    check($sformatf("u%0d_ch%0d_disparity_bound", u, c),
                          32'(disp[u][c] <= 10 && disp[u][c] >= -10), 32'd1);
                    if (u == 0 && py[0] == 0)
                        check($sformatf("u0_ch%0d_zero_word", c),
                              32'(w == 10'b0100000000 || w == 10'b1111111111), 32'd1);
                end else begin
                    disp[u][c] = 0;
                    check($sformatf("u%0d_ch%0d_blank(%0d,%0d)", u, c, px, py[u]),
                          32'(w), 32'(exp_blank(u, c, px, py[u])));
                end
            end
        end
        if (!(px < 1280 && py[0] < 720) && (tm[0][0] == C01 || tm[0][0] == C11)) hs_cnt++;
        if (px == 1649) begin
            check("u0_hsync_cycles_per_line", 32'(hs_cnt), 32'd40);
            hs_cnt = 0;
        end
        if (px == 0 && (tm[1][0] == C10 || tm[1][0] == C11)) vs_lines++;
        prime();
    endtask

    initial begin
        int guard;
        reset    = 1'b1;
        rgb      = '0;
        vs_lines = 0;
        reset_model();
        repeat (3) @(negedge clk);
        for (int u = 0; u < 3; u++) begin
            check("rst_cx", 32'(cx[u]), 32'd0);
            check("rst_cy", 32'(cy[u]), (u == 0) ? 32'd0 : 32'd717);
            check("frame_width", 32'(fw[u]), 32'd1650);
            check("frame_height", 32'(fh[u]), 32'd750);
            check("rst_tmds_clock", 32'(tclk[u]), 32'(TCK));
            for (int c = 0; c < 3; c++) check("rst_tmds", 32'(tm[u][c]), 32'(C00));
        end

        reset = 1'b0;
        prime();
        // u1/u2 run rows 717..749 and wrap to row 0; u0 covers rows 0..32.
        repeat (33 * 1650 + 20) step();
        check("u1_vsync_lines", 32'(vs_lines), 32'd5);

        guard = 0;
        while (px != 500 && guard < 2000) begin
            step();
            guard++;
        end
        check("reach_cx_500", 32'(px), 32'd500);

        reset = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            for (int u = 0; u < 3; u++) begin
                check("midrst_cx", 32'(cx[u]), 32'd0);
                check("midrst_cy", 32'(cy[u]), (u == 0) ? 32'd0 : 32'd717);
                check("midrst_tmds_clock", 32'(tclk[u]), 32'(TCK));
                for (int c = 0; c < 3; c++) check("midrst_tmds", 32'(tm[u][c]), 32'(C00));
            end
            @(negedge clk);
        end
        reset = 1'b0;
        reset_model();
        prime();
        repeat (1700) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
